mem_access_stage: RTL and testbench

Parametrised successor to the MEM pipeline stage in the five-stage MIPS core. It passes EX results through unchanged for non-memory instructions. It executes loads and stores (LB/LBU/LH/LHU/LW/SB/SH/SW/LL/SC) over a req/ack data bus with variable wait states, and stalls the pipeline until the access completes. It also owns the LL/SC link bit and detects misaligned addresses, and sits between the EX/MEM and MEM/WB registers.

---
 rtl/mem_pkg.sv | 45 ++++
 rtl/mem_lane_align.sv | 62 ++++++
 rtl/mem_access_stage.sv | 222 ++++++++++++++++++++++
 tb/tb_mem_access_stage.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
// mem_pkg : shared encodings for the MEM pipeline stage
// Rev 1.0 : initial release
// ============================================================================
package mem_pkg;

    typedef enum logic [3:0] {
        MEM_NONE = 4'd0,
        MEM_LB   = 4'd1,
        MEM_LBU  = 4'd2,
        MEM_LH   = 4'd3,
        MEM_LHU  = 4'd4,
        MEM_LW   = 4'd5,
        MEM_SB   = 4'd6,
        MEM_SH   = 4'd7,
        MEM_SW   = 4'd8,
        MEM_LL   = 4'd9,
        MEM_SC   = 4'd10
    } mem_op_e;

    localparam logic [1:0] EXCP_NONE        = 2'b00;
    localparam logic [1:0] EXCP_LOAD_ALIGN  = 2'b01;
    localparam logic [1:0] EXCP_STORE_ALIGN = 2'b10;
    localparam logic [1:0] EXCP_BUS         = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY  = 2'd1,
        ST_DONE  = 2'd2,
        ST_DRAIN = 2'd3
    } state_e;

    localparam int NOP_REG_ADDR = 0;

    function automatic logic is_load(mem_op_e op);
        return op inside {MEM_LB, MEM_LBU, MEM_LH, MEM_LHU, MEM_LW, MEM_LL};
    endfunction

    function automatic logic is_store(mem_op_e op);
        return op inside {MEM_SB, MEM_SH, MEM_SW, MEM_SC};
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_lane_align.sv
`default_nettype none
// ============================================================================
// mem_lane_align : big-endian byte enables, store replication, load
//                  extraction/extension and misalignment detection
// Rev 1.0 : initial release
// ============================================================================
module mem_lane_align
    import mem_pkg::*;
(
    input  mem_op_e     op,
    input  logic [1:0]  offset,
    input  logic [31:0] store_data,
    input  logic [31:0] rdata,
    output logic [3:0]  sel,
    output logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic        misaligned
);

    logic        is_byte;
    logic        is_half;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        is_byte = op inside {MEM_LB, MEM_LBU, MEM_SB};
        is_half = op inside {MEM_LH, MEM_LHU, MEM_SH};

        // Offset 0 is the most significant byte on the bus
        case (offset)
            2'd0:    lane_b = rdata[31:24];
            2'd1:    lane_b = rdata[23:16];
            2'd2:    lane_b = rdata[15:8];
            default: lane_b = rdata[7:0];
        endcase
        lane_h = offset[1] ? rdata[15:0] : rdata[31:16];

        if (is_byte) begin
            sel        = 4'b1000 >> offset;
            wdata      = {4{store_data[7:0]}};
            misaligned = 1'b0;
        end else if (is_half) begin
            sel        = offset[1] ? 4'b0011 : 4'b1100;
            wdata      = {2{store_data[15:0]}};
            misaligned = offset[0];
        end else begin
            sel        = 4'b1111;
            wdata      = store_data;
            misaligned = |offset;
        end

        case (op)
            MEM_LB:  load_data = {{24{lane_b[7]}}, lane_b};
            MEM_LBU: load_data = {24'd0, lane_b};
            MEM_LH:  load_data = {{16{lane_h[15]}}, lane_h};
            MEM_LHU: load_data = {16'd0, lane_h};
            default: load_data = rdata;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_access_stage.sv
`default_nettype none
// ============================================================================
// mem_access_stage : MEM pipeline stage with req/ack data bus, LL/SC link
//                    bit, misalignment and bus-timeout exceptions
// Rev 1.0 : initial release
// ============================================================================
module mem_access_stage
    import mem_pkg::*;
#(
    parameter int REGADDR_W = 5,
    parameter int ADDR_W    = 32,
    parameter int TIMEOUT   = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush_i,
    input  logic [3:0]           mem_op_i,
    input  logic [ADDR_W-1:0]    mem_addr_i,
    input  logic [31:0]          store_data_i,
    input  logic [REGADDR_W-1:0] wd_i,
    input  logic                 wreg_i,
    input  logic [31:0]          wdata_i,
    input  logic                 whilo_i,
    input  logic [31:0]          hi_i,
    input  logic [31:0]          lo_i,
    output logic [REGADDR_W-1:0] wd_o,
    output logic                 wreg_o,
    output logic [31:0]          wdata_o,
    output logic                 whilo_o,
    output logic [31:0]          hi_o,
    output logic [31:0]          lo_o,
    output logic                 stallreq_o,
    output logic [1:0]           excp_o,
    output logic                 bus_req_o,
    output logic                 bus_we_o,
    output logic [ADDR_W-1:0]    bus_addr_o,
    output logic [3:0]           bus_sel_o,
    output logic [31:0]          bus_wdata_o,
    input  logic                 bus_ack_i,
    input  logic [31:0]          bus_rdata_i,
    output logic                 llbit_o
);

    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    mem_op_e           op;
    logic              is_ld, is_st, is_mem;
    state_e            state, state_nxt;
    logic [CNT_W-1:0]  wait_cnt;
    logic [31:0]       rdata_q;
    logic              bus_err;
    logic              llbit;
    logic [ADDR_W-1:0] addr_q;
    logic [3:0]        sel_q;
    logic [31:0]       wdata_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_word;
    logic [3:0]        sel_c;
    logic [31:0]       wdata_c, load_data, mem_result;
    logic              misaligned, sc_fail, launch, timeout_hit, complete;

    assign op        = mem_op_e'(mem_op_i);
    assign is_ld     = is_load(op);
    assign is_st     = is_store(op);
    assign is_mem    = is_ld | is_st;
    assign addr_word = {mem_addr_i[ADDR_W-1:2], 2'b00};
    assign llbit_o   = llbit;

    mem_lane_align u_align (
        .op         (op),
        .offset     (mem_addr_i[1:0]),
        .store_data (store_data_i),
        .rdata      ((state == ST_DONE) ? rdata_q : bus_rdata_i),
        .sel        (sel_c),
        .wdata      (wdata_c),
        .load_data  (load_data),
        .misaligned (misaligned)
    );

    assign mem_result  = (op == MEM_SC) ? 32'd1 : load_data;
    assign sc_fail     = (op == MEM_SC) && !llbit;
    // A flushed instruction must never touch memory
    assign launch      = (state == ST_IDLE) && is_mem && !misaligned && !sc_fail && !flush_i;
    // The launch cycle is the first wait cycle, so the counter starts at 1 in BUSY
    assign timeout_hit = (TIMEOUT != 0) && ((32'(wait_cnt) + 32'd1) >= 32'(TIMEOUT));
    assign complete    = (launch && bus_ack_i) || ((state == ST_DONE) && !bus_err);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            wait_cnt <= '0;
            rdata_q  <= '0;
            bus_err  <= 1'b0;
            llbit    <= 1'b0;
            addr_q   <= '0;
            sel_q    <= '0;
            wdata_q  <= '0;
            we_q     <= 1'b0;
        end else begin
            state <= state_nxt;
            if (launch) begin
                addr_q   <= addr_word;
                sel_q    <= sel_c;
                wdata_q  <= wdata_c;
                we_q     <= is_st;
                wait_cnt <= CNT_W'(1);
                bus_err  <= 1'b0;
            end else if ((state == ST_BUSY || state == ST_DRAIN) && !bus_ack_i
                         && wait_cnt != '1) begin
                wait_cnt <= wait_cnt + CNT_W'(1);
            end
            if (state == ST_BUSY && !flush_i) begin
                if (bus_ack_i)
                    rdata_q <= bus_rdata_i;
                else if (timeout_hit)
                    bus_err <= 1'b1;
            end
            if (flush_i)
                llbit <= 1'b0;
            else if (complete && op == MEM_LL)
                llbit <= 1'b1;
            else if (complete && op == MEM_SC)
                llbit <= 1'b0;
        end
    end

    always_comb begin
        state_nxt   = state;
        wd_o        = wd_i;
        wreg_o      = wreg_i;
        wdata_o     = wdata_i;
        whilo_o     = whilo_i;
        hi_o        = hi_i;
        lo_o        = lo_i;
        stallreq_o  = 1'b0;
        excp_o      = EXCP_NONE;
        bus_req_o   = 1'b0;
        bus_we_o    = we_q;
        bus_addr_o  = addr_q;
        bus_sel_o   = sel_q;
        bus_wdata_o = wdata_q;

        case (state)
            ST_IDLE: begin
                bus_we_o    = is_st;
                bus_addr_o  = addr_word;
                bus_sel_o   = sel_c;
                bus_wdata_o = wdata_c;
                if (is_mem && misaligned) begin
                    wreg_o = 1'b0;
                    excp_o = is_st ? EXCP_STORE_ALIGN : EXCP_LOAD_ALIGN;
                end else if (sc_fail) begin
                    wdata_o = 32'd0;
                end else if (launch) begin
                    bus_req_o = 1'b1;
                    if (bus_ack_i) begin
                        if (is_ld || op == MEM_SC)
                            wdata_o = mem_result;
                    end else begin
                        stallreq_o = 1'b1;
                        wreg_o     = 1'b0;
                        state_nxt  = ST_BUSY;
                    end
                end
            end
            ST_BUSY: begin
                bus_req_o = 1'b1;
                wreg_o    = 1'b0;
                if (flush_i) begin
                    state_nxt = (bus_ack_i || timeout_hit) ? ST_IDLE : ST_DRAIN;
                end else begin
                    stallreq_o = 1'b1;
                    if (bus_ack_i || timeout_hit)
                        state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                if (is_ld || op == MEM_SC)
                    wdata_o = mem_result;
                if (bus_err) begin
                    wreg_o = 1'b0;
                    excp_o = EXCP_BUS;
                end
                state_nxt = ST_IDLE;
            end
            ST_DRAIN: begin
                bus_req_o = 1'b1;
                wreg_o    = 1'b0;
                whilo_o   = 1'b0;
                if (bus_ack_i || timeout_hit)
                    state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase

        if (flush_i) begin
            wreg_o  = 1'b0;
            whilo_o = 1'b0;
        end
        if (excp_o != EXCP_NONE)
            whilo_o = 1'b0;

        if (rst) begin
            state_nxt   = ST_IDLE;
            wd_o        = REGADDR_W'(NOP_REG_ADDR);
            wreg_o      = 1'b0;
            wdata_o     = '0;
            whilo_o     = 1'b0;
            hi_o        = '0;
            lo_o        = '0;
            stallreq_o  = 1'b0;
            excp_o      = EXCP_NONE;
            bus_req_o   = 1'b0;
            bus_we_o    = 1'b0;
            bus_addr_o  = '0;
            bus_sel_o   = '0;
            bus_wdata_o = '0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_stage.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_mem_access_stage : randomized bench with a bus slave and reference model
// Rev 1.0 : initial release
// ============================================================================
module tb_mem_access_stage;
    import mem_pkg::*;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush_i;
    logic [3:0]  mem_op_i;
    logic [31:0] mem_addr_i, store_data_i;
    logic [4:0]  wd_i;
    logic        wreg_i;
    logic [31:0] wdata_i;
    logic        whilo_i;
    logic [31:0] hi_i, lo_i;
    logic [4:0]  wd_o;
    logic        wreg_o;
    logic [31:0] wdata_o;
    logic        whilo_o;
    logic [31:0] hi_o, lo_o;
    logic        stallreq_o;
    logic [1:0]  excp_o;
    logic        bus_req_o, bus_we_o;
    logic [31:0] bus_addr_o;
    logic [3:0]  bus_sel_o;
    logic [31:0] bus_wdata_o;
    logic        bus_ack_i;
    logic [31:0] bus_rdata_i;
    logic        llbit_o;

    always #5 clk = ~clk;

    mem_access_stage #(.REGADDR_W(5), .ADDR_W(32), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .flush_i(flush_i), .mem_op_i(mem_op_i),
        .mem_addr_i(mem_addr_i), .store_data_i(store_data_i),
        .wd_i(wd_i), .wreg_i(wreg_i), .wdata_i(wdata_i),
        .whilo_i(whilo_i), .hi_i(hi_i), .lo_i(lo_i),
        .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o),
        .whilo_o(whilo_o), .hi_o(hi_o), .lo_o(lo_o),
        .stallreq_o(stallreq_o), .excp_o(excp_o),
        .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
        .bus_sel_o(bus_sel_o), .bus_wdata_o(bus_wdata_o),
        .bus_ack_i(bus_ack_i), .bus_rdata_i(bus_rdata_i), .llbit_o(llbit_o)
    );

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] mem [16];
    bit          ll_model;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model ----------------
    function automatic bit op_load(logic [3:0] op);
        return op == MEM_LB || op == MEM_LBU || op == MEM_LH || op == MEM_LHU
            || op == MEM_LW || op == MEM_LL;
    endfunction

    function automatic bit op_store(logic [3:0] op);
        return op == MEM_SB || op == MEM_SH || op == MEM_SW || op == MEM_SC;
    endfunction

    function automatic int unsigned op_size(logic [3:0] op);
        if (op == MEM_LB || op == MEM_LBU || op == MEM_SB) return 1;
        if (op == MEM_LH || op == MEM_LHU || op == MEM_SH) return 2;
        return 4;
    endfunction

    function automatic logic [31:0] ref_sel(logic [3:0] op, logic [31:0] a);
        int unsigned sz, off;
        sz  = op_size(op);
        off = a % 4;
        return ((32'd1 << sz) - 1) << (4 - sz - off);
    endfunction

    function automatic logic [31:0] ref_wdata(logic [3:0] op, logic [31:0] sd);
        int unsigned sz;
        sz = op_size(op);
        if (sz == 1) return (sd % 256) * 32'h0101_0101;
        if (sz == 2) return (sd % 65536) * 32'h0001_0001;
        return sd;
    endfunction

    function automatic logic [31:0] ref_load(logic [3:0] op, logic [31:0] a, logic [31:0] w);
        longint unsigned v, span;
        int unsigned     sz, off;
        sz   = op_size(op);
        off  = a % 4;
        span = 64'd1 << (8 * sz);
        v    = (64'(w) >> (8 * (4 - sz - off))) % span;
        if ((op == MEM_LB || op == MEM_LH) && v >= span / 2)
            v = v + (64'h1_0000_0000 - span);
        return v[31:0];
    endfunction

    function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] nw, logic [31:0] sel);
        logic [31:0] m;
        m = 32'd0;
        for (int b = 0; b < 4; b++)
            if (sel[b]) m = m | (32'hFF << (8 * b));
        return (old & ~m) | (nw & m);
    endfunction

    function automatic int unsigned widx(logic [31:0] a);
        return (a >> 2) % 16;
    endfunction

    // Runs one instruction to completion, serving the bus with `dly` unacked cycles
    task automatic run_op(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] sd,
                          input int dly, input logic [4:0] wd, input logic wreg,
                          input logic [31:0] wdat);
        bit ld, st, mis, scf, acc, tmo, done, first;
        int reqs, stalls, cyc, exp_reqs, exp_stalls;
        logic [31:0] exp_load, exp_wdata;
        logic [1:0]  exp_excp;
        logic        exp_wreg, whl;

        ld  = op_load(op);
        st  = op_store(op);
        mis = (ld || st) && (addr % op_size(op) != 0);
        scf = (op == MEM_SC) && !mis && !ll_model;
        acc = (ld || st) && !mis && !scf;
        tmo = acc && dly >= TO;
        exp_reqs   = !acc ? 0 : (tmo ? TO : dly + 1);
        exp_stalls = !acc ? 0 : (tmo ? TO : (dly == 0 ? 0 : dly + 1));
        exp_load   = ref_load(op, addr, mem[widx(addr)]);
        exp_excp   = mis ? (st ? 2'b10 : 2'b01) : (tmo ? 2'b11 : 2'b00);
        exp_wreg   = (mis || tmo) ? 1'b0 : wreg;
        exp_wdata  = scf ? 32'd0 : (acc && op == MEM_SC) ? 32'd1 : (acc && ld) ? exp_load : wdat;
        whl        = 1'($urandom % 2);

        mem_op_i = op; mem_addr_i = addr; store_data_i = sd; flush_i = 1'b0;
        wd_i = wd; wreg_i = wreg; wdata_i = wdat; whilo_i = whl;
        hi_i = $urandom; lo_i = $urandom;

        reqs = 0; stalls = 0; cyc = 0; done = 0; first = 1;
        while (!done && cyc < 16) begin
            #2;
            if (bus_req_o) begin
                if (first) begin
                    check("bus_addr", bus_addr_o, addr & 32'hFFFF_FFFC);
                    check("bus_we", 32'(bus_we_o), 32'(st));
                    check("bus_sel", 32'(bus_sel_o), ref_sel(op, addr));
                    if (st) check("bus_wdata", bus_wdata_o, ref_wdata(op, sd));
                    first = 0;
                end
                if (reqs == dly) begin
                    bus_ack_i   = 1'b1;
                    bus_rdata_i = mem[widx(addr)];
                    if (acc && st)
                        mem[widx(addr)] = merge(mem[widx(addr)], ref_wdata(op, sd), ref_sel(op, addr));
                end
            end
            #2;
            if (cyc == 0) check("llbit", 32'(llbit_o), 32'(ll_model));
            if (bus_req_o) reqs++;
            if (stallreq_o) begin
                stalls++;
            end else begin
                done = 1;
                check("wd_o", 32'(wd_o), 32'(wd));
                check("wreg_o", 32'(wreg_o), 32'(exp_wreg));
                if (exp_wreg) check("wdata_o", wdata_o, exp_wdata);
                check("excp_o", 32'(excp_o), 32'(exp_excp));
                check("whilo_o", 32'(whilo_o), 32'(whl && exp_excp == 2'b00));
                check("hi_o", hi_o, hi_i);
            end
            next_cycle();
            bus_ack_i   = 1'b0;
            bus_rdata_i = $urandom;
            cyc++;
        end
        check("op_done", 32'(done), 32'd1);
        check("req_cycles", 32'(reqs), 32'(exp_reqs));
        check("stall_cycles", 32'(stalls), 32'(exp_stalls));
        if (acc && !tmo && op == MEM_LL) ll_model = 1;
        if (acc && !tmo && op == MEM_SC) ll_model = 0;
    endtask

    task automatic flush_pulse;
        mem_op_i = MEM_NONE; flush_i = 1'b1; wreg_i = 1'b1; whilo_i = 1'b1;
        #4;
        check("flush_wreg", 32'(wreg_o), 32'd0);
        check("flush_whilo", 32'(whilo_o), 32'd0);
        check("flush_req", 32'(bus_req_o), 32'd0);
        next_cycle();
        flush_i  = 1'b0;
        ll_model = 0;
    endtask

    // Flush lands mid-transfer: the pipeline moves on while the bus drains
    task automatic flush_busy;
        logic [31:0] a;
        a = 32'h0000_1010;
        mem_op_i = MEM_LW; mem_addr_i = a; wreg_i = 1'b1; wd_i = 5'd9;
        flush_i = 1'b0; whilo_i = 1'b0;
        #4;
        check("fb_req0", 32'(bus_req_o), 32'd1);
        check("fb_stall0", 32'(stallreq_o), 32'd1);
        next_cycle();
        flush_i = 1'b1;
        #4;
        check("fb_stall1", 32'(stallreq_o), 32'd0);
        check("fb_wreg1", 32'(wreg_o), 32'd0);
        check("fb_req1", 32'(bus_req_o), 32'd1);
        next_cycle();
        mem_op_i = MEM_NONE; flush_i = 1'b0; wreg_i = 1'b1; wd_i = 5'd3;
        wdata_i = 32'h1234_5678; mem_addr_i = 32'hFFFF_FFF0;
        #2;
        check("drain_req", 32'(bus_req_o), 32'd1);
        check("drain_addr", bus_addr_o, a);
        check("drain_stall", 32'(stallreq_o), 32'd0);
        bus_ack_i = 1'b1; bus_rdata_i = 32'hBADB_AD00;
        #2;
        check("drain_wreg", 32'(wreg_o), 32'd0);
        next_cycle();
        bus_ack_i = 1'b0;
        #4;
        check("post_drain_req", 32'(bus_req_o), 32'd0);
        check("post_drain_wreg", 32'(wreg_o), 32'd1);
        check("post_drain_wdata", wdata_o, 32'h1234_5678);
        check("post_drain_llbit", 32'(llbit_o), 32'd0);
        next_cycle();
        ll_model = 0;
    endtask

    initial begin
        logic [3:0]  op;
        logic [31:0] addr;
        int          r, dly;

        rst = 1'b1; flush_i = 1'b0; mem_op_i = MEM_LW; mem_addr_i = 32'h100;
        store_data_i = '0; wd_i = 5'd7; wreg_i = 1'b1; wdata_i = 32'hFFFF_FFFF;
        whilo_i = 1'b1; hi_i = 32'h1; lo_i = 32'h2; bus_ack_i = 1'b0; bus_rdata_i = '0;
        ll_model = 0;
        for (int i = 0; i < 16; i++) mem[i] = $urandom;
        next_cycle(); next_cycle();
        #4;
        check("rst_wd", 32'(wd_o), 32'd0);
        check("rst_wreg", 32'(wreg_o), 32'd0);
        check("rst_wdata", wdata_o, 32'd0);
        check("rst_whilo", 32'(whilo_o), 32'd0);
        check("rst_stall", 32'(stallreq_o), 32'd0);
        check("rst_req", 32'(bus_req_o), 32'd0);
        check("rst_excp", 32'(excp_o), 32'd0);
        check("rst_llbit", 32'(llbit_o), 32'd0);
        next_cycle();
        rst = 1'b0;

        // Directed cases
        run_op(MEM_NONE, 32'h0, 32'h0, 0, 5'd5, 1'b1, 32'hDEAD_BEEF);
        mem[widx(32'h1001)] = 32'h1182_7344;
        run_op(MEM_LB, 32'h1001, 32'h0, 2, 5'd4, 1'b1, 32'h0);
        run_op(MEM_SH, 32'h2002, 32'h0000_ABCD, 0, 5'd0, 1'b0, 32'h0);
        run_op(MEM_LW, 32'h3001, 32'h0, 0, 5'd6, 1'b1, 32'h0);
        run_op(MEM_LL, 32'h40, 32'h0, 1, 5'd8, 1'b1, 32'h0);
        run_op(MEM_SC, 32'h40, 32'hCAFE_F00D, 0, 5'd8, 1'b1, 32'h0);
        run_op(MEM_LL, 32'h40, 32'h0, 0, 5'd8, 1'b1, 32'h0);
        flush_pulse();
        run_op(MEM_SC, 32'h40, 32'h1357_9BDF, 0, 5'd8, 1'b1, 32'hFFFF_FFFF);
        run_op(MEM_LW, 32'h44, 32'h0, 10, 5'd2, 1'b1, 32'h0);
        flush_busy();

        // Randomized traffic
        for (int n = 0; n < 300; n++) begin
            op   = 4'($urandom_range(0, 10));
            addr = 32'h1000 + $urandom_range(0, 63);
            if ($urandom % 2 == 0) addr = addr & 32'hFFFF_FFFC;
            r   = $urandom_range(0, 7);
            dly = (r < 3) ? 0 : (r < 7) ? $urandom_range(1, 3) : $urandom_range(4, 6);
            if ($urandom_range(0, 19) == 0)
                flush_pulse();
            run_op(op, addr, $urandom, dly, 5'($urandom),
                   (op_load(op) || op == MEM_SC) ? 1'b1 : (op_store(op) ? 1'b0 : 1'($urandom % 2)),
                   $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
